// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, flag bit positions and EX/MEM control bundle
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic wr_en;
    logic mem_rd;
    logic mem_wr;
  } exmem_ctrl_t;

  // Arithmetic ops own all three flags.
  function automatic logic op_sets_znv(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Logic/shift ops only touch Z; V and N keep their old values.
  function automatic logic op_sets_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/ex_result_stage_flag_unit.sv
// flag_unit: opcode-class decode, Z/V/N compute and the architectural flag register
// EX_FLAG_BYPASS_EN exposes the next-state flags combinationally.
module flag_unit
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd,
  input  logic [3:0]    op,
  input  logic [DW-1:0] sum,
  input  logic          err,
`ifdef EX_FLAG_BYPASS_EN
  output logic [2:0]    flags_next,
`endif
  output logic [2:0]    flags
);

  logic [2:0] flags_q, flags_d;
  logic       upd_all, upd_z;

  // Next flags: Z for any flag-setting op, V/N only for ADD/SUB, else hold.
  always_comb begin
    upd_all = upd && op_sets_znv(op);
    upd_z   = upd_all || (upd && op_sets_z_only(op));
    flags_d = flags_q;
    flags_d[FLAG_Z] = upd_z ? (sum == '0) : flags_q[FLAG_Z];
    flags_d[FLAG_V] = upd_all ? err : flags_q[FLAG_V];
    flags_d[FLAG_N] = upd_all ? sum[DW-1] : flags_q[FLAG_N];
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;
`ifdef EX_FLAG_BYPASS_EN
  assign flags_next = flags_d;
`endif

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX/MEM pipeline register with stall/flush and the flag register
// EX_FLAG_BYPASS_EN adds the flags_next output for bubble-free branch resolution.
module ex_result_stage
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [3:0]    ex_op,
  input  logic [DW-1:0] ex_sum,
  input  logic          ex_error,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wr_en,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic [DW-1:0] ex_store_data,
  input  logic          stall,
  input  logic          flush,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_rd,
  output logic          mem_wr_en,
  output logic          mem_mem_rd,
  output logic          mem_mem_wr,
  output logic [DW-1:0] mem_store_data,
`ifdef EX_FLAG_BYPASS_EN
  output logic [2:0]    flags_next,
`endif
  output logic [2:0]    flags
);

  logic          load;
  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] store_q, store_d;
  exmem_ctrl_t   ctrl_q, ctrl_d, ex_ctrl;

  assign load = !stall && !flush;

  // Stall holds everything; flush (without stall) bubbles valid and controls
  // while data fields keep their previous contents.
  always_comb begin
    ex_ctrl  = '{wr_en: ex_wr_en & ex_valid, mem_rd: ex_mem_rd & ex_valid, mem_wr: ex_mem_wr & ex_valid};
    valid_d  = stall ? valid_q : (flush ? 1'b0 : ex_valid);
    ctrl_d   = stall ? ctrl_q : (flush ? exmem_ctrl_t'('0) : ex_ctrl);
    result_d = load ? ex_sum : result_q;
    rd_d     = load ? ex_rd : rd_q;
    store_d  = load ? ex_store_data : store_q;
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
      store_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      store_q  <= store_d;
    end
  end

  flag_unit #(.DW(DW)) u_flag (
    .clk   (clk),
    .rst   (rst),
    .upd   (load && ex_valid),
    .op    (ex_op),
    .sum   (ex_sum),
    .err   (ex_error),
`ifdef EX_FLAG_BYPASS_EN
    .flags_next(flags_next),
`endif
    .flags (flags)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_rd         = rd_q;
  assign mem_wr_en      = ctrl_q.wr_en;
  assign mem_mem_rd     = ctrl_q.mem_rd;
  assign mem_mem_wr     = ctrl_q.mem_wr;
  assign mem_store_data = store_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: table-driven scoreboard bench for ex_result_stage
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_error, ex_wr_en, ex_mem_rd, ex_mem_wr, stall, flush;
  logic [3:0]  ex_op, ex_rd;
  logic [15:0] ex_sum, ex_store_data;
  logic        mem_valid, mem_wr_en, mem_mem_rd, mem_mem_wr;
  logic [15:0] mem_result, mem_store_data;
  logic [3:0]  mem_rd;
  logic [2:0]  flags;
`ifdef EX_FLAG_BYPASS_EN
  logic [2:0]  flags_next;
`endif

  always #5 clk = ~clk;

  ex_result_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_sum(ex_sum),
    .ex_error(ex_error), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
    .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_store_data(mem_store_data),
`ifdef EX_FLAG_BYPASS_EN
    .flags_next(flags_next),
`endif
    .flags(flags)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] sum;
    logic        err, valid;
    logic [2:0]  ctl;
    logic [3:0]  rd;
    logic [15:0] sd;
    logic        st, fl;
    logic        e_valid;
    logic [15:0] e_res;
    logic [3:0]  e_rd;
    logic [2:0]  e_ctl;
    logic [15:0] e_sd;
    logic [2:0]  e_flags;
  } vec_t;

  vec_t vec [19];
  vec_t sb [$];
  vec_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, {15'd0, mem_valid}, 16'h0);
    chk({tag, " result"}, mem_result, 16'h0);
    chk({tag, " rd"}, {12'd0, mem_rd}, 16'h0);
    chk({tag, " ctrl"}, {13'd0, mem_wr_en, mem_mem_rd, mem_mem_wr}, 16'h0);
    chk({tag, " store"}, mem_store_data, 16'h0);
    chk({tag, " flags"}, {13'd0, flags}, 16'h0);
  endtask

  initial begin
    //          op    sum      err valid ctl    rd    sd       st fl | valid res      rd    ctl    sd       flags
    vec[0]  = '{4'h0, 16'h7FFF, 1, 1, 3'b100, 4'd3, 16'h1111, 0, 0, 1, 16'h7FFF, 4'd3, 3'b100, 16'h1111, 3'b010};
    vec[1]  = '{4'h1, 16'h0000, 0, 1, 3'b100, 4'd4, 16'h0000, 0, 0, 1, 16'h0000, 4'd4, 3'b100, 16'h0000, 3'b100};
    vec[2]  = '{4'h2, 16'h8001, 1, 1, 3'b100, 4'd5, 16'h2222, 0, 0, 1, 16'h8001, 4'd5, 3'b100, 16'h2222, 3'b000};
    vec[3]  = '{4'h0, 16'h8000, 1, 1, 3'b001, 4'd6, 16'hABCD, 0, 0, 1, 16'h8000, 4'd6, 3'b001, 16'hABCD, 3'b011};
    vec[4]  = '{4'h1, 16'h8005, 0, 1, 3'b100, 4'd7, 16'h0000, 0, 0, 1, 16'h8005, 4'd7, 3'b100, 16'h0000, 3'b001};
    vec[5]  = '{4'h7, 16'h0000, 0, 1, 3'b100, 4'd8, 16'h0000, 0, 0, 1, 16'h0000, 4'd8, 3'b100, 16'h0000, 3'b001};
    vec[6]  = '{4'h8, 16'h0040, 0, 1, 3'b110, 4'd1, 16'h0000, 0, 0, 1, 16'h0040, 4'd1, 3'b110, 16'h0000, 3'b001};
    vec[7]  = '{4'h0, 16'h0000, 0, 0, 3'b111, 4'd2, 16'h5555, 0, 0, 0, 16'h0000, 4'd2, 3'b000, 16'h5555, 3'b001};
    vec[8]  = '{4'h6, 16'h0001, 0, 1, 3'b100, 4'd9, 16'h0000, 0, 0, 1, 16'h0001, 4'd9, 3'b100, 16'h0000, 3'b001};
    vec[9]  = '{4'h0, 16'h0000, 0, 1, 3'b100, 4'd2, 16'h7777, 1, 0, 1, 16'h0001, 4'd9, 3'b100, 16'h0000, 3'b001};
    vec[10] = '{4'h0, 16'h0000, 0, 1, 3'b100, 4'd2, 16'h7777, 1, 0, 1, 16'h0001, 4'd9, 3'b100, 16'h0000, 3'b001};
    vec[11] = '{4'h0, 16'h0000, 0, 1, 3'b100, 4'd2, 16'h7777, 1, 0, 1, 16'h0001, 4'd9, 3'b100, 16'h0000, 3'b001};
    vec[12] = '{4'h0, 16'h0000, 0, 1, 3'b100, 4'd2, 16'h7777, 0, 0, 1, 16'h0000, 4'd2, 3'b100, 16'h7777, 3'b100};
    vec[13] = '{4'h0, 16'h7FFF, 1, 1, 3'b100, 4'd5, 16'h8888, 0, 1, 0, 16'h0000, 4'd2, 3'b000, 16'h7777, 3'b100};
    vec[14] = '{4'h1, 16'h8000, 0, 1, 3'b111, 4'd6, 16'h9999, 1, 1, 0, 16'h0000, 4'd2, 3'b000, 16'h7777, 3'b100};
    vec[15] = '{4'h5, 16'hFFFF, 0, 1, 3'b001, 4'd7, 16'h1234, 0, 0, 1, 16'hFFFF, 4'd7, 3'b001, 16'h1234, 3'b000};
    vec[16] = '{4'hF, 16'h0000, 0, 1, 3'b000, 4'd0, 16'h0000, 0, 0, 1, 16'h0000, 4'd0, 3'b000, 16'h0000, 3'b000};
    vec[17] = '{4'h0, 16'h8000, 1, 1, 3'b100, 4'd1, 16'h0000, 0, 0, 1, 16'h8000, 4'd1, 3'b100, 16'h0000, 3'b011};
    vec[18] = '{4'h2, 16'h0000, 0, 1, 3'b100, 4'd2, 16'h0000, 0, 0, 1, 16'h0000, 4'd2, 3'b100, 16'h0000, 3'b111};

    rst = 1'b1;
    {ex_valid, ex_error, ex_wr_en, ex_mem_rd, ex_mem_wr, stall, flush} = '0;
    ex_op = '0; ex_rd = '0; ex_sum = '0; ex_store_data = '0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ex_op = vec[i].op; ex_sum = vec[i].sum; ex_error = vec[i].err; ex_valid = vec[i].valid;
      {ex_wr_en, ex_mem_rd, ex_mem_wr} = vec[i].ctl;
      ex_rd = vec[i].rd; ex_store_data = vec[i].sd; stall = vec[i].st; flush = vec[i].fl;
      sb.push_back(vec[i]);
`ifdef EX_FLAG_BYPASS_EN
      #1 chk($sformatf("v%0d flags_next", i), {13'd0, flags_next}, {13'd0, vec[i].e_flags});
`endif
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d valid", i), {15'd0, mem_valid}, {15'd0, e.e_valid});
        chk($sformatf("v%0d result", i), mem_result, e.e_res);
        chk($sformatf("v%0d rd", i), {12'd0, mem_rd}, {12'd0, e.e_rd});
        chk($sformatf("v%0d ctrl", i), {13'd0, mem_wr_en, mem_mem_rd, mem_mem_wr}, {13'd0, e.e_ctl});
        chk($sformatf("v%0d store", i), mem_store_data, e.e_sd);
        chk($sformatf("v%0d flags", i), {13'd0, flags}, {13'd0, e.e_flags});
      end
    end

    // Asynchronous reset mid-operation: mem_valid=1, flags=111 going in.
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    chk_all_zero("reset_held");
    rst = 1'b0;
    ex_valid = 1'b1; ex_op = 4'h1; ex_sum = 16'h0000; ex_error = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1 chk("post_reset flags", {13'd0, flags}, 16'h0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
